// File: rtl/mixer_requant.sv
// Two-stage requantizer: rounded (half-up) right shift of an unsigned product, saturated to OUT_WIDTH.
// Optional saturating clip counter enabled by defining MIXER_REQUANT_CLIP_CNT_EN.
module mixer_requant #(
    parameter int IN_WIDTH    = 79,
    parameter int OUT_WIDTH   = 24,
    parameter int SHIFT_WIDTH = 7
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [IN_WIDTH-1:0]    din,
    input  logic                   din_vld,
    output logic                   din_rdy,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [OUT_WIDTH-1:0]   dout,
    output logic                   dout_vld,
    input  logic                   dout_rdy,
    output logic                   clip,
    output logic [15:0]            clip_cnt,
    input  logic                   clip_clr
);

    localparam logic [IN_WIDTH:0] ONE = {{IN_WIDTH{1'b0}}, 1'b1};

    logic                   s1_vld;
    logic [IN_WIDTH-1:0]    s1_din;
    logic [SHIFT_WIDTH-1:0] s1_shift;
    logic                   s2_adv;
    logic [IN_WIDTH:0]      rnd;
    logic [IN_WIDTH:0]      sum;
    logic [IN_WIDTH:0]      res;
    logic                   sat;
    logic [OUT_WIDTH-1:0]   q;

    assign s2_adv  = !dout_vld || dout_rdy;
    assign din_rdy = !ap_rst && (!s1_vld || s2_adv);

    // Rounding constant shifts out of range (to zero) for very large shifts; the result is zero anyway.
    always_comb begin
        rnd = '0;
        if (s1_shift != '0) begin
            rnd = ONE << (s1_shift - SHIFT_WIDTH'(1));
        end
        sum = {1'b0, s1_din} + rnd;
        res = sum >> s1_shift;
        sat = |res[IN_WIDTH:OUT_WIDTH];
        q   = sat ? '1 : res[OUT_WIDTH-1:0];
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_vld   <= 1'b0;
            s1_din   <= '0;
            s1_shift <= '0;
            dout_vld <= 1'b0;
            dout     <= '0;
            clip     <= 1'b0;
        end else begin
            if (din_rdy) begin
                s1_vld <= din_vld;
                if (din_vld) begin
                    s1_din   <= din;
                    s1_shift <= shift;
                end
            end
            if (s2_adv) begin
                dout_vld <= s1_vld;
                if (s1_vld) begin
                    dout <= q;
                    clip <= sat;
                end
            end
        end
    end

`ifdef MIXER_REQUANT_CLIP_CNT_EN
    always_ff @(posedge ap_clk) begin
        if (ap_rst || clip_clr) begin
            clip_cnt <= '0;
        end else if (dout_vld && dout_rdy && clip && clip_cnt != '1) begin
            clip_cnt <= clip_cnt + 16'd1;
        end
    end
`else
    logic unused_clip_clr;
    assign unused_clip_clr = clip_clr;
    assign clip_cnt        = '0;
`endif

endmodule

// File: tb/tb_mixer_requant.sv
// Directed self-checking bench for mixer_requant; clip counter checks follow MIXER_REQUANT_CLIP_CNT_EN.
module tb_mixer_requant;

    logic        ap_clk;
    logic        ap_rst;
    logic [78:0] din;
    logic        din_vld;
    logic        din_rdy;
    logic [6:0]  shift;
    logic [23:0] dout;
    logic        dout_vld;
    logic        dout_rdy;
    logic        clip;
    logic [15:0] clip_cnt;
    logic        clip_clr;

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] exp_cnt = '0;

    mixer_requant #(.IN_WIDTH(79), .OUT_WIDTH(24), .SHIFT_WIDTH(7)) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .din      (din),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .shift    (shift),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .clip     (clip),
        .clip_cnt (clip_cnt),
        .clip_clr (clip_clr)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single isolated beat with dout_rdy high; checks 2-cycle latency, value, clip and counter.
    task automatic beat(input string tag, input logic [78:0] d, input logic [6:0] s,
                        input logic [23:0] ed, input logic ec);
        din = d; shift = s; din_vld = 1'b1; dout_rdy = 1'b1;
        @(posedge ap_clk); #1;
        din_vld = 1'b0; din = '0;
        chk({tag, "_lat1"}, 80'(dout_vld), 80'(0));
        @(posedge ap_clk); #1;
        chk({tag, "_vld"}, 80'(dout_vld), 80'(1));
        chk({tag, "_dout"}, 80'(dout), 80'(ed));
        chk({tag, "_clip"}, 80'(clip), 80'(ec));
`ifdef MIXER_REQUANT_CLIP_CNT_EN
        if (ec && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
        @(posedge ap_clk); #1;
        chk({tag, "_cnt"}, 80'(clip_cnt), 80'(exp_cnt));
        chk({tag, "_empty"}, 80'(dout_vld), 80'(0));
    endtask

    logic [78:0] p78;
    logic [78:0] ones;
    logic [3:0]  pat;
    int          sent;
    int          rcvd;
    logic        held;
    logic [23:0] hold_val;
    logic        acc;
    logic        outp;
    logic [23:0] oval;

    initial begin
        ap_rst = 1'b1; din = '0; din_vld = 1'b0; shift = '0; dout_rdy = 1'b0; clip_clr = 1'b0;
        p78  = 79'd1 << 78;
        ones = {79{1'b1}};
        pat  = 4'b1001;

        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_vld", 80'(dout_vld), 80'(0));
        chk("rst_rdy", 80'(din_rdy), 80'(0));
        chk("rst_dout", 80'(dout), 80'(0));
        chk("rst_clip", 80'(clip), 80'(0));
        chk("rst_cnt", 80'(clip_cnt), 80'(0));
        ap_rst = 1'b0;
        #1;
        chk("rel_rdy", 80'(din_rdy), 80'(1));

        beat("lat", 79'h1_0000_0000, 7'd16, 24'h010000, 1'b0);
        beat("rnd_up", 79'h18, 7'd4, 24'd2, 1'b0);
        beat("rnd_dn", 79'h17, 7'd4, 24'd1, 1'b0);
        beat("sh0", 79'd5, 7'd0, 24'd5, 1'b0);
        beat("sat", 79'h100_0000_0000, 7'd8, 24'hFFFFFF, 1'b1);
        beat("max_pass", 79'hFF_FFFF, 7'd0, 24'hFFFFFF, 1'b0);
        beat("max_clip", 79'h100_0000, 7'd0, 24'hFFFFFF, 1'b1);
        beat("rnd_clip", 79'hFFFF_FF80, 7'd8, 24'hFFFFFF, 1'b1);
        beat("sh79_carry", p78, 7'd79, 24'd1, 1'b0);
        beat("sh79_nocarry", p78 - 79'd1, 7'd79, 24'd0, 1'b0);
        beat("sh80_zero", ones, 7'd80, 24'd0, 1'b0);
        beat("sh127_zero", ones, 7'd127, 24'd0, 1'b0);

        // Back-pressure: 10 beats, dout_rdy cycling 1,0,0,1; beat i yields i+1.
        sent = 0; rcvd = 0; held = 1'b0; hold_val = '0;
        for (int cyc = 0; cyc < 80 && rcvd < 10; cyc++) begin
            dout_rdy = pat[3 - (cyc % 4)];
            din_vld  = (sent < 10);
            din      = 79'(sent * 16 + 8);
            shift    = 7'd4;
            #1;
            chk("bp_rdy", 80'(din_rdy), 80'(!((sent - rcvd) == 2 && !dout_rdy)));
            if (held) begin
                chk("bp_hold_vld", 80'(dout_vld), 80'(1));
                chk("bp_hold_dout", 80'(dout), 80'(hold_val));
            end
            acc      = din_vld && din_rdy;
            outp     = dout_vld && dout_rdy;
            oval     = dout;
            held     = dout_vld && !dout_rdy;
            hold_val = dout;
            if (outp) begin
                chk("bp_data", 80'(oval), 80'(rcvd + 1));
                rcvd++;
            end
            if (acc) sent++;
            @(posedge ap_clk); #1;
        end
        chk("bp_count", 80'(rcvd), 80'(10));
        din_vld = 1'b0; dout_rdy = 1'b1;
        @(posedge ap_clk); #1;
        chk("bp_drain", 80'(dout_vld), 80'(0));

        // Reset with two beats in flight and the output stalled.
        dout_rdy = 1'b0; din = 79'h18; shift = 7'd4; din_vld = 1'b1;
        @(posedge ap_clk); #1;
        din = 79'h28;
        @(posedge ap_clk); #1;
        din_vld = 1'b0;
        chk("mr_pre_vld", 80'(dout_vld), 80'(1));
        ap_rst = 1'b1;
        #1;
        chk("mr_rst_rdy", 80'(din_rdy), 80'(0));
        @(posedge ap_clk); #1;
        chk("mr_vld", 80'(dout_vld), 80'(0));
        chk("mr_dout", 80'(dout), 80'(0));
        chk("mr_cnt", 80'(clip_cnt), 80'(0));
        ap_rst = 1'b0; dout_rdy = 1'b1; exp_cnt = '0;
        #1;
        chk("mr_rel_rdy", 80'(din_rdy), 80'(1));
        for (int i = 0; i < 4; i++) begin
            @(posedge ap_clk); #1;
            chk("mr_no_out", 80'(dout_vld), 80'(0));
        end
        beat("post_rst", 79'd5, 7'd0, 24'd5, 1'b0);

`ifdef MIXER_REQUANT_CLIP_CNT_EN
        // Saturate the counter with 65536 clipping beats, then clear during a clipped handshake.
        sent = 0;
        din = 79'h100_0000_0000; shift = 7'd8; dout_rdy = 1'b1;
        for (int cyc = 0; cyc < 70000 && sent < 65536; cyc++) begin
            din_vld = 1'b1;
            #1;
            if (din_rdy) sent++;
            @(posedge ap_clk); #1;
        end
        din_vld = 1'b0;
        chk("cc_sent", 80'(sent), 80'(65536));
        repeat (3) @(posedge ap_clk);
        #1;
        chk("cc_sat", 80'(clip_cnt), 80'(16'hFFFF));
        din_vld = 1'b1;
        @(posedge ap_clk); #1;
        din_vld = 1'b0;
        @(posedge ap_clk); #1;
        chk("cc_clr_vld", 80'(dout_vld), 80'(1));
        chk("cc_clr_clip", 80'(clip), 80'(1));
        clip_clr = 1'b1;
        @(posedge ap_clk); #1;
        clip_clr = 1'b0;
        chk("cc_clr", 80'(clip_cnt), 80'(0));
        exp_cnt = '0;
        beat("cc_after", 79'h100_0000_0000, 7'd8, 24'hFFFFFF, 1'b1);
`else
        clip_clr = 1'b1;
        beat("cc_off", 79'h100_0000_0000, 7'd8, 24'hFFFFFF, 1'b1);
        clip_clr = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mixer_requant.md
MIXER_REQUANT -- requirements
Module: mixer_requant

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 79: width of the unsigned product from the mixer multiplier.
REQ-002 SHALL have parameter OUT_WIDTH, default 24: width of the unsigned output sample.
REQ-003 SHALL have parameter SHIFT_WIDTH, default 7: width of the shift control.
REQ-004 SHALL have port ap_clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port ap_rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port din, input, IN_WIDTH: unsigned product.
REQ-007 SHALL have port din_vld, input, 1: din is valid.
REQ-008 SHALL have port din_rdy, output, 1: block accepts din this cycle.
REQ-009 SHALL have port shift, input, SHIFT_WIDTH: right-shift amount, sampled with each accepted beat.
REQ-010 SHALL have port dout, output, OUT_WIDTH: requantized sample.
REQ-011 SHALL have port dout_vld, output, 1: dout is valid.
REQ-012 SHALL have port dout_rdy, input, 1: downstream accepts dout.
REQ-013 SHALL have port clip, output, 1: the current dout was saturated; qualified by dout_vld.
REQ-014 SHALL have port clip_cnt, output, 16: saturating count of clipped beats (present only per REQ-031).
REQ-015 SHALL have port clip_clr, input, 1: synchronous clear of clip_cnt (present only per REQ-031).

Function
REQ-016 SHALL accept a beat when din_vld and din_rdy are both high on a rising edge.
REQ-017 SHALL be a two-stage pipeline: S1 registers din and shift; S2 registers the rounded, saturated result and clip.
REQ-018 SHALL give latency of exactly 2 cycles from acceptance to dout_vld when dout_rdy is held high.
REQ-019 SHALL compute result = (din + R) >> shift in IN_WIDTH+1 bits, with R = 2^(shift-1) for shift>0 and R = 0 for shift=0 (round half up).
REQ-020 SHALL produce result 0 with clip low for shift >= IN_WIDTH+1; shift = IN_WIDTH yields 1 only if rounding carries.
REQ-021 SHALL output dout = 2^OUT_WIDTH-1 and clip = 1 when result > 2^OUT_WIDTH-1; otherwise dout = result[OUT_WIDTH-1:0] and clip = 0.
REQ-022 SHALL advance S2 when S2 is empty or dout_rdy is high, and advance S1 into S2 under the same condition.
REQ-023 SHALL drive din_rdy = !S1_valid || S2_advance, giving full throughput of 1 beat/cycle with no bubbles.
REQ-024 SHALL hold dout, clip and dout_vld stable while dout_vld is high and dout_rdy is low.
REQ-025 SHALL not drop, duplicate or reorder beats under any din_vld/dout_rdy pattern.
REQ-026 SHALL keep din_rdy free of combinational dependence on din_vld.

Reset
REQ-027 SHALL, while ap_rst is high, clear S1_valid and S2_valid, drive dout_vld = 0, din_rdy = 0, dout = 0, clip = 0, clip_cnt = 0.
REQ-028 SHALL discard all in-flight beats when ap_rst asserts mid-stream; no beat presented before reset appears after it.
REQ-029 SHALL drive din_rdy = 1 on the first cycle after ap_rst deasserts.

Configuration
REQ-030 SHALL gate the clip counter with macro MIXER_REQUANT_CLIP_CNT_EN.
REQ-031 SHALL, with MIXER_REQUANT_CLIP_CNT_EN defined, increment clip_cnt by 1 on each dout handshake with clip = 1, saturate at 16'hFFFF, clear on clip_clr with clear taking priority over same-cycle increment.
REQ-032 SHALL, without MIXER_REQUANT_CLIP_CNT_EN, omit clip_cnt register logic, tie clip_cnt to 0 and ignore clip_clr; all other behaviour identical.

Verification
REQ-033 SHALL verify: din = 0x1_0000_0000 (2^32), shift = 16, dout_rdy = 1 -> dout = 0x010000, clip = 0, dout_vld exactly 2 cycles after acceptance.
REQ-034 SHALL verify rounding: din = 0x18, shift = 4 -> dout = 2; din = 0x17, shift = 4 -> dout = 1; din = 5, shift = 0 -> dout = 5.
REQ-035 SHALL verify saturation: din = 2^40, shift = 8 -> dout = 0xFFFFFF, clip = 1; clip_cnt increments by 1 at handshake (macro defined).
REQ-036 SHALL verify back-pressure: 10 back-to-back beats with dout_rdy toggling 1,0,0,1 pattern -> all 10 outputs in order, dout held stable while stalled, din_rdy low only while both stages are full and stalled.
REQ-037 SHALL verify reset mid-stream: 2 beats in flight, assert ap_rst 1 cycle -> dout_vld = 0 next cycle, neither beat emitted, din_rdy = 1 after release.
REQ-038 SHALL verify clip_cnt saturation and clear: preload via 65536 clipping beats -> clip_cnt = 0xFFFF; clip_clr with coincident clipped handshake -> clip_cnt = 0.
